// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide controller for the E stage.
//
// Owns the HI/LO register pair. A start pulse in IDLE with a multiply or
// divide op computes the 64-bit result right away and holds it as a pending
// value. The pending value is committed to HI/LO when the busy window ends.
// MTHI/MTLO write HI or LO directly, with no busy window.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   MD instruction valid in E (one-cycle pulse)
//   op[2:0]   in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   a[31:0]   in   forwarded rs
//   b[31:0]   in   forwarded rt
//   d_is_md   in   D-stage instruction touches the MDU
//   busy      out  operation in flight (state == RUN)
//   md_stall  out  d_is_md & (busy | start), combinational
//   hi, lo    out  HI/LO registers
//
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB (ops 6/7).
// Ops 6/7 accumulate into {hi,lo} with the MULT_CYCLES latency. Without
// the macro, ops 6/7 are no-ops and no accumulate adder is built.
//
// Handshake: start is a one-cycle pulse. It is accepted only in IDLE and is
// ignored while busy. The pipeline uses md_stall to make sure no start
// arrives while busy is high.

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;

  // Products: the low 64 bits of a 64x64 multiply of extended operands give
  // the exact signed or unsigned 32x32 product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes and the signs are fixed afterwards.
  // This gives a defined result for 0x80000000 / -1: the quotient wraps to
  // 0x80000000 and the remainder is 0.
  logic        b_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign b_zero = (b == 32'd0);
  assign a_mag  = a[31] ? (~a + 32'd1) : a;
  assign b_mag  = b[31] ? (~b + 32'd1) : b;
  assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
  assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
  assign q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = b_zero ? 32'd0 : a / b;
  assign r_u    = b_zero ? 32'd0 : a % b;

`ifdef MDU_MADD_EN
  // The accumulate uses the HI/LO value present at the start edge. HI/LO
  // cannot change during RUN, so this is the value the programmer sees.
  logic [63:0] acc;
  assign acc = (op == 3'd7) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              {phi_d, plo_d} = prod_s;
              cnt_d          = MULT_LD;
              state_d        = S_RUN;
            end
            3'd1: begin
              {phi_d, plo_d} = prod_u;
              cnt_d          = MULT_LD;
              state_d        = S_RUN;
            end
            3'd2, 3'd3: begin
              // On divide by zero the pending value is the current HI/LO.
              // The commit then leaves both registers unchanged.
              if (b_zero)         {phi_d, plo_d} = {hi_q, lo_q};
              else if (op == 3'd2) {phi_d, plo_d} = {r_s, q_s};
              else                {phi_d, plo_d} = {r_u, q_u};
              cnt_d   = DIV_LD;
              state_d = S_RUN;
            end
            3'd4: hi_d = a;
            3'd5: lo_d = a;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: begin
              {phi_d, plo_d} = acc;
              cnt_d          = MULT_LD;
              state_d        = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign md_stall = d_is_md & (busy | start);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed and random checks of mdu_ctrl with a result
// scoreboard. Expected {hi,lo} values are pushed when an operation starts.
// They are popped and compared when the busy window closes.

module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_is_md;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // start must never arrive while busy
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(start && busy)) else begin
        fails++;
        $error("FAIL start_while_busy obs=1 exp=0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference model for the multiply/divide ops.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint sp;
    longint unsigned up;
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (o)
      3'd0: begin sp = longint'(sx) * longint'(sy); return 64'(sp); end
      3'd1: begin up = longint'(x) * longint'(y); return 64'(up); end
      3'd2: return (y == 0) ? cur : {32'(sx % sy), 32'(sx / sy)};
      3'd3: return (y == 0) ? cur : {x % y, x / y};
      default: return cur;
    endcase
  endfunction

  // driver: issue one busy-window op and score its commit
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [63:0] exp, input int ncyc);
    int n;
    logic [63:0] e;
    exp_q.push_back(exp);
    start = 1'b1; op = o; a = ra; b = rb;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      chk({tag, "_stall"}, {63'd0, md_stall}, {63'd0, d_is_md});
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
    e = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, e);
    {m_hi, m_lo} = e;
  endtask

  // driver: MTHI/MTLO or a no-op style op with no busy window
  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] ra);
    start = 1'b1; op = o; a = ra; b = 32'd0;
    tick();
    start = 1'b0;
    if (o == 3'd4) m_hi = ra;
    if (o == 3'd5) m_lo = ra;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;

    repeat (2) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_stall", {63'd0, md_stall}, 64'd0);
      chk("idle_hilo", {hi, lo}, 64'd0);
    end

    // directed arithmetic
    run_md("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
    run_md("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 5);
    run_md("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
    run_md("divu_by0", 3'd3, 32'd7, 32'd0, {m_hi, m_lo}, 10);
    run_md("div_by0", 3'd2, 32'd9, 32'd0, {m_hi, m_lo}, 10);

    // md_stall window with d_is_md held: cycles T..T+5 high, T+6 low
    d_is_md = 1'b1;
    exp_q.push_back(64'd1);
    start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
    #1;
    chk("stall_T", {63'd0, md_stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("stall_win", {63'd0, md_stall}, 64'd1);
      tick();
    end
    chk("stall_T6", {63'd0, md_stall}, 64'd0);
    chk("stall_T6_busy", {63'd0, busy}, 64'd0);
    chk("stall_hilo", {hi, lo}, exp_q.pop_front());
    {m_hi, m_lo} = 64'd1;
    d_is_md = 1'b0;

    // d_is_md low: run_md checks md_stall==0 on every busy cycle
    run_md("mult_nostall", 3'd0, 32'd5, 32'd6, 64'd30, 5);

    // MTHI / MTLO
    run_mt("mthi", 3'd4, 32'h1234_5678);
    tick();
    chk("mthi_later_busy", {63'd0, busy}, 64'd0);
    run_mt("mtlo", 3'd5, 32'hCAFE_0001);

`ifdef MDU_MADD_EN
    run_mt("mthi0", 3'd4, 32'd0);
    run_mt("mtlo10", 3'd5, 32'd10);
    run_md("madd", 3'd6, 32'd3, 32'd4, 64'd22, 5);
    run_md("msub", 3'd7, 32'd5, 32'd5, 64'hFFFF_FFFF_FFFF_FFFD, 5);
`else
    run_mt("op6_noop", 3'd6, 32'd3);
    run_mt("op7_noop", 3'd7, 32'd5);
`endif

    // random multiply/divide ops against the model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'(i % 4);
      ra = $urandom();
      rb = (ro >= 3'd2) ? 32'($urandom_range(1, 1000)) : $urandom();
      if (ro == 3'd2 && $urandom_range(0, 1) == 1) rb = -rb;
      run_md("rand", ro, ra, rb, model(ro, ra, rb, {m_hi, m_lo}),
             (ro >= 3'd2) ? 10 : 5);
    end

    // reset on the 3rd busy cycle of a DIV aborts with no commit
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_pre_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_commit", {31'd0, busy, hi}, 64'd0);
    end
    chk("abort_lo", {32'd0, lo}, 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller for the 5-stage pipeline. Sits in the E stage and owns the HI/LO register pair. It accepts one MD operation per start pulse and sequences a fixed-latency busy window. It also raises the MD-hazard stall that the pipeline stall logic ORs into its global stall.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MSUB); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage MD instruction valid this cycle (one-cycle pulse per instruction)
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
a  input  32  E-stage forwarded rs value
b  input  32  E-stage forwarded rt value
d_is_md  input  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo/madd/msub
busy  output  1  operation in flight
md_stall  output  1  stall request to the hazard unit
hi  output  32  HI register (read by mfhi in E)
lo  output  32  LO register (read by mflo in E)

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0. Reset mid-operation aborts; no commit occurs.
- States: IDLE, RUN. busy = (state==RUN); the 4-bit counter is nonzero exactly in RUN.
- IDLE + start + op in {0..3, 6, 7 when enabled}: at edge T, latch the computed 64-bit pending result {phi,plo} and load the counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- RUN: the counter decrements each edge. On the edge where the counter goes 1 -> 0, commit hi<=phi, lo<=plo and go to IDLE. busy is high in cycles T+1..T+N. mfhi/mflo in E at cycle T+N+1 sees the new value.
- MTHI/MTLO with start in IDLE: hi<=a (or lo<=a) at edge T; no busy window; the other register is unchanged.
- start while busy: ignored, no state change. The stall logic guarantees this never happens; the verifier asserts it never happens.
- Arithmetic:
  - MULT: signed 32x32 -> 64, hi = product[63:32], lo = product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed, quotient truncated toward zero -> lo; remainder takes the dividend's sign -> hi.
  - DIVU: unsigned.
- Divide by zero (b==0): full DIV_CYCLES busy window; at commit, hi and lo keep their previous values.
- md_stall = d_is_md & (busy | start). The window covers the start cycle so that a back-to-back MD instruction in D is held. md_stall is combinational; no registered outputs other than hi, lo and busy.
- Simultaneous commit edge and a new start in the same cycle: impossible, because busy=1 blocks start.
- Ops 6/7 without the feature: treated as no-op; no busy window and no HI/LO change.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: op 6 MADD computes {hi,lo} + signed(a)*signed(b); op 7 MSUB computes {hi,lo} - signed(a)*signed(b). Both are 64-bit wrap-around, use MULT_CYCLES latency, and read the {hi,lo} value present at the start edge.
- Undefined: ops 6/7 are no-ops as above, and no accumulate adder is synthesized.

Test Plan:
- Reset then idle -> busy=0, hi=0, lo=0, md_stall=0 for 3 cycles.
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; after the window hi=0xFFFFFFFF, lo=0xFFFFFFFA. With MULTU and the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 -> hi/lo unchanged after 10 cycles.
- d_is_md=1 held with start at cycle T -> md_stall=1 on cycles T..T+5 (MULT_CYCLES=5), 0 at T+6. With d_is_md=0 throughout, md_stall stays 0 while busy=1.
- MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, busy never asserts, lo unchanged. Assert reset on the 3rd cycle of a DIV -> busy=0 and hi/lo=0 immediately, with no later commit.
- (MDU_MADD_EN) hi=0, lo=10, then MADD a=3, b=4 -> lo=22 after 5 cycles; then MSUB a=5, b=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
